// File: rtl/module_spi_slave_rx_tx_if.sv
// Pin and local-bus bundle for the SPI responder.
// The slave modport is the responder's view; master is the view of whoever drives the SPI pins and the TX/RX bus.
interface module_spi_slave_rx_tx_if #(
    parameter int DATA_W = 8
);
    // Handshakes: tx_wr_i is a one-cycle write strobe with no ready (a write while full overwrites);
    // rx_valid_o, tx_underrun_o and frame_err_o are one-cycle pulses with no backpressure.
    logic              sclk_i;
    logic              ss_i;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_wr_i;
    logic              tx_full_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              tx_underrun_o;
    logic              frame_err_o;
    logic              busy_o;

    modport slave (
        input  sclk_i, ss_i, mosi_i, tx_data_i, tx_wr_i,
        output miso_o, miso_oe_o, tx_full_o, rx_data_o, rx_valid_o,
               tx_underrun_o, frame_err_o, busy_o
    );

    modport master (
        output sclk_i, ss_i, mosi_i, tx_data_i, tx_wr_i,
        input  miso_o, miso_oe_o, tx_full_o, rx_data_o, rx_valid_o,
               tx_underrun_o, frame_err_o, busy_o
    );
endinterface

// File: rtl/module_spi_slave_rx_tx.sv
// SPI mode-0 responder, MSB first, oversampling sclk/ss/mosi on the system clock.
// One-entry TX buffer feeds the shift register at each frame start; busy_o exposes the IDLE/ACTIVE state.
module module_spi_slave_rx_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    module_spi_slave_rx_tx_if.slave spi
);

    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_rise_q, sclk_fall_q, ss_rise_q, ss_fall_q;
    logic [FLUSH_W-1:0]     flush_q;
    logic                   armed_q;

    state_e                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-2:0]      tx_sh_q;
    logic [DATA_W-2:0]      rx_sh_q;
    logic [DATA_W-1:0]      buf_q;
    logic                   buf_full_q;

    logic                   miso_q, miso_oe_q, busy_q;
    logic [DATA_W-1:0]      rx_data_q;
    logic                   rx_valid_q, underrun_q, frame_err_q;

    logic                   sclk_s, ss_s, mosi_s;
    logic                   start_frame, wrap_frame, load_tx;
    logic [DATA_W-1:0]      load_word_d;
    logic [DATA_W-1:0]      rx_word_d;

    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        start_frame = (state_q == IDLE) && ss_fall_q && armed_q;
        wrap_frame  = (state_q == ACTIVE) && !ss_rise_q && sclk_fall_q && (bit_cnt_q == CNT_FULL);
        load_tx     = start_frame || wrap_frame;
        load_word_d = buf_full_q ? buf_q : '0;
        rx_word_d   = {rx_sh_q, mosi_s};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ss_rise_q   <= 1'b0;
            ss_fall_q   <= 1'b0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            ss_rise_q   <= ss_s & ~ss_prev_q;
            ss_fall_q   <= ~ss_s & ss_prev_q;

            // Frames only start once a genuine high level on ss has crossed the synchronizer
            // after reset, so a reset released mid-frame cannot fake an ss fall.
            if (flush_q != FLUSH_DONE) begin
                flush_q <= flush_q + FLUSH_W'(1);
            end else if (ss_s) begin
                armed_q <= 1'b1;
            end

            if (spi.tx_wr_i) begin
                buf_q      <= spi.tx_data_i;
                buf_full_q <= 1'b1;
            end else if (load_tx) begin
                buf_full_q <= 1'b0;
            end

            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (start_frame) begin
                        state_q    <= ACTIVE;
                        tx_sh_q    <= load_word_d[DATA_W-2:0];
                        miso_q     <= load_word_d[DATA_W-1];
                        miso_oe_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                        underrun_q <= !buf_full_q;
                    end
                end
                ACTIVE: begin
                    if (ss_rise_q) begin
                        state_q   <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        // A last bit landing together with ss rise still completes the word.
                        if (sclk_rise_q && bit_cnt_q == CNT_LAST) begin
                            rx_data_q  <= rx_word_d;
                            rx_valid_q <= 1'b1;
                        end else if (bit_cnt_q != '0 && bit_cnt_q != CNT_FULL) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise_q) begin
                        if (bit_cnt_q != CNT_FULL) begin
                            rx_sh_q   <= rx_word_d[DATA_W-2:0];
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_LAST) begin
                                rx_data_q  <= rx_word_d;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end else if (sclk_fall_q) begin
                        if (wrap_frame) begin
                            tx_sh_q    <= load_word_d[DATA_W-2:0];
                            miso_q     <= load_word_d[DATA_W-1];
                            bit_cnt_q  <= '0;
                            underrun_q <= !buf_full_q;
                        end else if (bit_cnt_q != '0) begin
                            miso_q  <= tx_sh_q[DATA_W-2];
                            tx_sh_q <= {tx_sh_q[DATA_W-3:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.miso_o        = miso_q;
    assign spi.miso_oe_o     = miso_oe_q;
    assign spi.tx_full_o     = buf_full_q;
    assign spi.rx_data_o     = rx_data_q;
    assign spi.rx_valid_o    = rx_valid_q;
    assign spi.tx_underrun_o = underrun_q;
    assign spi.frame_err_o   = frame_err_q;
    assign spi.busy_o        = busy_q;

endmodule
